// File: rtl/seven_seg_display_arbiter.sv
// seven_seg_display_arbiter
//   Round-robin time-slice arbiter that shares one 8-digit seven-segment
//   display driver among N_REQ requesters. A new owner keeps the display
//   for at least HOLD_MS millisecond ticks (HOLD). After that the slice is
//   OPEN and the owner is rotated out as soon as someone else asks.
//   If the owner drops its request, the display is released immediately.
//
// Ports
//   clock        system clock, all logic on posedge
//   reset        asynchronous, active-high
//   req          per-requester request
//   req_number   requester i value at [32*i+31:32*i]
//   req_mode     requester i radix (0 = decimal/BCD, 1 = hex)
//   req_points   requester i decimal points at [8*i+7:8*i]
//   grant        one-hot owner, zero when idle
//   disp_number  to display driver input_number
//   disp_mode    to display driver mode
//   disp_points  to display driver dec_points
//   slice_done   high while the owner's minimum slice has elapsed
module seven_seg_display_arbiter #(
    parameter int N_REQ    = 4,
    parameter int TICK_DIV = 100000,
    parameter int HOLD_MS  = 500
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [32*N_REQ-1:0]  req_number,
    input  logic [N_REQ-1:0]     req_mode,
    input  logic [8*N_REQ-1:0]   req_points,
    output logic [N_REQ-1:0]     grant,
    output logic [31:0]          disp_number,
    output logic                 disp_mode,
    output logic [7:0]           disp_points,
    output logic                 slice_done
);

    localparam int IW = $clog2(N_REQ);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HW = $clog2(HOLD_MS + 1);

    typedef enum logic [1:0] {IDLE, HOLD, OPEN} state_t;

    state_t          state_reg, state_next;
    logic [IW-1:0]   owner_reg, owner_next;
    logic [IW-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [HW-1:0]   hold_cnt_reg, hold_cnt_next;
    logic [TW-1:0]   tick_cnt_reg, tick_cnt_next;
    logic [31:0]     disp_number_reg, disp_number_next;
    logic            disp_mode_reg, disp_mode_next;
    logic [7:0]      disp_points_reg, disp_points_next;

    logic            tick;
    logic [N_REQ-1:0] owner_mask;
    logic            owner_req;
    logic            others_req;

    logic [31:0]     number_arr [N_REQ];
    logic [7:0]      points_arr [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign number_arr[gi] = req_number[32*gi +: 32];
            assign points_arr[gi] = req_points[8*gi +: 8];
        end
    endgenerate

    // First requester after p (wrapping), p itself considered last.
    function automatic logic [IW-1:0] arb(input logic [IW-1:0] p,
                                          input logic [N_REQ-1:0] r);
        logic [IW-1:0] pick;
        logic [IW-1:0] idx;
        logic          found;
        pick  = p;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = IW'((int'(p) + k) % N_REQ);
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Free-running millisecond tick; its phase is deliberately not tied to grants.
    assign tick          = (tick_cnt_reg == TW'(TICK_DIV - 1));
    assign tick_cnt_next = tick ? '0 : tick_cnt_reg + TW'(1);

    assign owner_mask = N_REQ'(1) << owner_reg;
    assign owner_req  = req[owner_reg];
    assign others_req = |(req & ~owner_mask);

    always_comb begin
        state_next       = state_reg;
        owner_next       = owner_reg;
        rr_ptr_next      = rr_ptr_reg;
        hold_cnt_next    = hold_cnt_reg;
        disp_number_next = '0;
        disp_mode_next   = 1'b0;
        disp_points_next = '0;

        case (state_reg)
            IDLE: begin
                if (|req) begin
                    owner_next    = arb(rr_ptr_reg, req);
                    rr_ptr_next   = owner_next;
                    hold_cnt_next = HW'(HOLD_MS);
                    state_next    = HOLD;
                end
            end
            HOLD, OPEN: begin
                // Release takes priority over expiry and rotation.
                if (!owner_req) begin
                    if (|req) begin
                        owner_next    = arb(owner_reg, req);
                        rr_ptr_next   = owner_next;
                        hold_cnt_next = HW'(HOLD_MS);
                        state_next    = HOLD;
                    end else begin
                        hold_cnt_next = '0;
                        state_next    = IDLE;
                    end
                end else if (state_reg == HOLD) begin
                    if (tick) begin
                        if (hold_cnt_reg == HW'(1)) begin
                            hold_cnt_next = '0;
                            state_next    = OPEN;
                        end else begin
                            hold_cnt_next = hold_cnt_reg - HW'(1);
                        end
                    end
                end else if (others_req) begin
                    // Owner still requesting, so ARB(owner) lands on someone else.
                    owner_next    = arb(owner_reg, req);
                    rr_ptr_next   = owner_next;
                    hold_cnt_next = HW'(HOLD_MS);
                    state_next    = HOLD;
                end
            end
            default: state_next = IDLE;
        endcase

        // Display fields always come from the single owner selected for next cycle.
        if (state_next != IDLE) begin
            disp_number_next = number_arr[owner_next];
            disp_mode_next   = req_mode[owner_next];
            disp_points_next = points_arr[owner_next];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            owner_reg       <= '0;
            rr_ptr_reg      <= IW'(N_REQ - 1);
            hold_cnt_reg    <= '0;
            tick_cnt_reg    <= '0;
            disp_number_reg <= '0;
            disp_mode_reg   <= 1'b0;
            disp_points_reg <= '0;
        end else begin
            state_reg       <= state_next;
            owner_reg       <= owner_next;
            rr_ptr_reg      <= rr_ptr_next;
            hold_cnt_reg    <= hold_cnt_next;
            tick_cnt_reg    <= tick_cnt_next;
            disp_number_reg <= disp_number_next;
            disp_mode_reg   <= disp_mode_next;
            disp_points_reg <= disp_points_next;
        end
    end

    assign grant       = (state_reg != IDLE) ? owner_mask : '0;
    assign slice_done  = (state_reg == OPEN);
    assign disp_number = disp_number_reg;
    assign disp_mode   = disp_mode_reg;
    assign disp_points = disp_points_reg;

endmodule

// File: tb/tb_seven_seg_display_arbiter.sv
// Testbench for seven_seg_display_arbiter (N_REQ=4, TICK_DIV=4, HOLD_MS=3).
// A behavioural model tracks owner, remaining slice ticks and tick phase.
module tb_seven_seg_display_arbiter;

    localparam int N  = 4;
    localparam int TD = 4;
    localparam int HM = 3;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req = '0;
    logic [32*N-1:0] req_number = '0;
    logic [N-1:0]   req_mode = '0;
    logic [8*N-1:0] req_points = '0;
    logic [N-1:0]   grant;
    logic [31:0]    disp_number;
    logic           disp_mode;
    logic [7:0]     disp_points;
    logic           slice_done;

    seven_seg_display_arbiter #(.N_REQ(N), .TICK_DIV(TD), .HOLD_MS(HM)) dut (
        .clock(clock), .reset(reset), .req(req), .req_number(req_number),
        .req_mode(req_mode), .req_points(req_points), .grant(grant),
        .disp_number(disp_number), .disp_mode(disp_mode),
        .disp_points(disp_points), .slice_done(slice_done)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    // Model state: owner index (-1 = nobody), round-robin pointer,
    // remaining ms of the minimum slice, free-running tick phase.
    int   m_owner, m_rr, m_hold, m_tick;
    bit   m_open;
    logic [N-1:0] exp_grant;
    logic [31:0]  exp_num;
    logic         exp_mode;
    logic [7:0]   exp_pts;
    logic         exp_done;

    function automatic int arb(int p, logic [N-1:0] r);
        int idx;
        for (int k = 1; k <= N; k++) begin
            idx = (p + k) % N;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic int grant_idx(logic [N-1:0] g);
        for (int i = 0; i < N; i++) if (g == (N'(1) << i)) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_rr = N - 1; m_hold = 0; m_tick = 0; m_open = 0;
        exp_grant = '0; exp_num = '0; exp_mode = 0; exp_pts = '0; exp_done = 0;
    endtask

    task automatic give_to(int o);
        m_owner = o; m_rr = o; m_hold = HM; m_open = 0;
    endtask

    // Advance model by one edge from the current inputs, then clock the DUT.
    task automatic step();
        bit tick;
        tick   = (m_tick == TD - 1);
        m_tick = tick ? 0 : m_tick + 1;
        if (m_owner < 0) begin
            if (req != 0) give_to(arb(m_rr, req));
        end else if (!req[m_owner]) begin
            if (req != 0) give_to(arb(m_owner, req));
            else begin m_owner = -1; m_hold = 0; m_open = 0; end
        end else if (!m_open) begin
            if (tick) begin
                m_hold--;
                if (m_hold == 0) m_open = 1;
            end
        end else if ((req & ~(N'(1) << m_owner)) != 0) begin
            give_to(arb(m_owner, req));
        end
        if (m_owner >= 0) begin
            exp_grant = N'(1) << m_owner;
            exp_num   = req_number[32*m_owner +: 32];
            exp_mode  = req_mode[m_owner];
            exp_pts   = req_points[8*m_owner +: 8];
            exp_done  = m_open;
        end else begin
            exp_grant = '0; exp_num = '0; exp_mode = 0; exp_pts = '0; exp_done = 0;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic randomize_fields();
        for (int i = 0; i < N; i++) begin
            req_number[32*i +: 32] = $urandom;
            req_points[8*i +: 8]   = 8'($urandom);
        end
        req_mode = N'($urandom);
    endtask

    task automatic test_reset();
        model_reset();
        randomize_fields();
        req = '0;
        #3;
        checks++;
        if (grant !== '0 || disp_number !== '0 || disp_mode !== 1'b0 ||
            disp_points !== '0 || slice_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got grant=%b num=%h mode=%b pts=%h done=%b want all 0",
                     grant, disp_number, disp_mode, disp_points, slice_done);
        end
        @(negedge clock);
        reset = 1'b0;
        step();
        checks++;
        if (grant !== '0) begin
            failures++;
            $display("FAIL idle_no_req: got grant=%b want 0000", grant);
        end
        $display("test_reset done");
    endtask

    task automatic test_single_grant();
        int n;
        do_reset();
        randomize_fields();
        req_number[31:0] = 32'h1234;
        req = 4'b0001;
        step();
        checks++;
        if (grant !== 4'b0001 || disp_number !== 32'h1234) begin
            failures++;
            $display("FAIL single_grant: got grant=%b num=%h want 0001 00001234", grant, disp_number);
        end
        n = 0;
        while (slice_done !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (n < 9 || n > 12) begin
            failures++;
            $display("FAIL single_slice_len: got %0d cycles want 9..12", n);
        end
        checks++;
        if (slice_done !== exp_done || grant !== exp_grant) begin
            failures++;
            $display("FAIL single_open: got done=%b grant=%b want done=%b grant=%b",
                     slice_done, grant, exp_done, exp_grant);
        end
        $display("test_single_grant slice_cycles=%0d", n);
    endtask

    task automatic test_alternate();
        int prev, cur, len, slices;
        do_reset();
        randomize_fields();
        req_mode = 4'b0010;
        req = 4'b0011;
        prev = -1; len = 0; slices = 0;
        for (int c = 0; c < 70; c++) begin
            step();
            checks++;
            if (grant !== exp_grant || disp_number !== exp_num || disp_mode !== exp_mode ||
                disp_points !== exp_pts || slice_done !== exp_done) begin
                failures++;
                $display("FAIL alt_cycle%0d: got g=%b n=%h m=%b p=%h d=%b want g=%b n=%h m=%b p=%h d=%b",
                         c, grant, disp_number, disp_mode, disp_points, slice_done,
                         exp_grant, exp_num, exp_mode, exp_pts, exp_done);
            end
            cur = grant_idx(grant);
            if (cur == prev) len++;
            else begin
                if (prev >= 0) begin
                    // Grant lasts the 9..12 cycle HOLD plus the one OPEN cycle.
                    checks++;
                    if (len < 10 || len > 13 || cur != 1 - prev) begin
                        failures++;
                        $display("FAIL alt_slice: got len=%0d next=%0d want 10..13 next=%0d",
                                 len, cur, 1 - prev);
                    end
                    slices++;
                end
                prev = cur; len = 1;
            end
        end
        checks++;
        if (slices < 4) begin
            failures++;
            $display("FAIL alt_count: got %0d slice changes want >=4", slices);
        end
        $display("test_alternate slices=%0d", slices);
    endtask

    task automatic test_release_mid_hold();
        do_reset();
        randomize_fields();
        req = 4'b0101;
        repeat (3) step();
        checks++;
        if (grant !== 4'b0001) begin
            failures++;
            $display("FAIL rel_first: got grant=%b want 0001", grant);
        end
        req = 4'b0100;
        step();
        checks++;
        if (grant !== 4'b0100 || disp_number !== req_number[95:64] || slice_done !== 1'b0) begin
            failures++;
            $display("FAIL rel_handover: got grant=%b num=%h done=%b want 0100 %h 0",
                     grant, disp_number, slice_done, req_number[95:64]);
        end
        for (int c = 0; c < 14; c++) begin
            step();
            checks++;
            if (slice_done !== exp_done || grant !== exp_grant) begin
                failures++;
                $display("FAIL rel_reload%0d: got done=%b grant=%b want done=%b grant=%b",
                         c, slice_done, grant, exp_done, exp_grant);
            end
        end
        $display("test_release_mid_hold done");
    endtask

    task automatic test_fairness();
        int order[$];
        int cur, prev;
        int want[5] = '{3, 0, 1, 2, 3};
        do_reset();
        randomize_fields();
        req = 4'b1000;
        step();
        order.push_back(grant_idx(grant));
        prev = grant_idx(grant);
        req = 4'b1111;
        for (int c = 0; c < 80 && order.size() < 5; c++) begin
            step();
            checks++;
            if (grant !== exp_grant) begin
                failures++;
                $display("FAIL fair_cycle%0d: got grant=%b want %b", c, grant, exp_grant);
            end
            cur = grant_idx(grant);
            if (cur != prev) begin
                order.push_back(cur);
                prev = cur;
            end
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (i >= order.size() || order[i] != want[i]) begin
                failures++;
                $display("FAIL fair_order%0d: got %0d want %0d", i,
                         (i < order.size()) ? order[i] : -1, want[i]);
            end
        end
        $display("test_fairness owners_seen=%0d", order.size());
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        randomize_fields();
        req_number[31:0] = 32'hDEAD_BEEF;
        req_points[7:0]  = 8'hA5;
        req_mode[0]      = 1'b1;
        req = 4'b0001;
        repeat (3) step();
        checks++;
        if (grant !== 4'b0001 || slice_done !== 1'b0) begin
            failures++;
            $display("FAIL rst_pre: got grant=%b done=%b want 0001 0", grant, slice_done);
        end
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if (grant !== '0 || disp_number !== '0 || disp_mode !== 1'b0 ||
            disp_points !== '0 || slice_done !== 1'b0) begin
            failures++;
            $display("FAIL rst_async: got grant=%b num=%h mode=%b pts=%h done=%b want all 0",
                     grant, disp_number, disp_mode, disp_points, slice_done);
        end
        @(negedge clock);
        req = 4'b0100;
        @(negedge clock);
        reset = 1'b0;
        step();
        checks++;
        if (grant !== 4'b0100 || disp_number !== req_number[95:64]) begin
            failures++;
            $display("FAIL rst_regrant: got grant=%b num=%h want 0100 %h",
                     grant, disp_number, req_number[95:64]);
        end
        $display("test_reset_mid_hold done");
    endtask

    task automatic test_release_at_expiry();
        int n;
        do_reset();
        randomize_fields();
        req = 4'b0001;
        step();
        n = 0;
        while (!(m_hold == 1 && m_tick == TD - 1 && !m_open) && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (n >= 20) begin
            failures++;
            $display("FAIL expiry_wait: got %0d cycles want <20", n);
        end
        req = '0;
        step();
        checks++;
        if (grant !== '0 || disp_number !== '0 || slice_done !== 1'b0) begin
            failures++;
            $display("FAIL expiry_release: got grant=%b num=%h done=%b want 0000 0 0",
                     grant, disp_number, slice_done);
        end
        $display("test_release_at_expiry done");
    endtask

    task automatic test_random();
        int k;
        do_reset();
        randomize_fields();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 7) == 0) req = N'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                k = $urandom_range(0, N - 1);
                req_number[32*k +: 32] = $urandom;
                req_points[8*k +: 8]   = 8'($urandom);
                req_mode[k]            = 1'($urandom);
            end
            step();
            checks++;
            if (grant !== exp_grant || disp_number !== exp_num || disp_mode !== exp_mode ||
                disp_points !== exp_pts || slice_done !== exp_done || !$onehot0(grant)) begin
                failures++;
                $display("FAIL rand_cycle%0d: got g=%b n=%h m=%b p=%h d=%b want g=%b n=%h m=%b p=%h d=%b",
                         c, grant, disp_number, disp_mode, disp_points, slice_done,
                         exp_grant, exp_num, exp_mode, exp_pts, exp_done);
            end
        end
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_single_grant();
        test_alternate();
        test_release_mid_hold();
        test_fairness();
        test_reset_mid_hold();
        test_release_at_expiry();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
